// File: rtl/id_1.sv
// Instruction decode stage: register-file addressing, reserved-instruction
// detection, branch/jump resolution with one-cycle redirect pulses,
// load-use hazard detection and the ID/EX pipeline register.
// The exception/interrupt flush input is named intr ("int" is a keyword).
module id_1 #(
    parameter int RI_CHECK = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        intr,
    input  logic        delay_hard,
    input  logic [31:0] id_inst,
    input  logic [31:0] id_pc,
    input  logic [1:0]  IC_IF,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        branch_1,
    output logic        j,
    output logic        jr,
    output logic [31:0] jr_data,
    output logic        jr_data_ok,
    output logic        delay_soft,
    output logic [31:0] ex_inst,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs_val,
    output logic [31:0] ex_rt_val,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_waddr,
    output logic [2:0]  ex_IC
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        legal;
    logic        ri;
    logic        uses_rt;
    logic        taken;
    logic        is_j;
    logic        is_jr;
    logic        ex_is_load;
    logic        suppress;
    logic [4:0]  waddr;
    logic [31:0] imm;

    assign opcode  = id_inst[31:26];
    assign rs      = id_inst[25:21];
    assign rt      = id_inst[20:16];
    assign rd      = id_inst[15:11];
    assign funct   = id_inst[5:0];
    assign rs_addr = rs;
    assign rt_addr = rt;

    // Decode: legality, destination register, immediate, branch/jump resolution
    always_comb begin
        legal = (opcode[5:4] == 2'b00) ||
                (opcode inside {6'b010000, 6'b100000, 6'b100001, 6'b100011,
                                6'b100100, 6'b100101, 6'b101000, 6'b101001,
                                6'b101011});
        ri      = (RI_CHECK != 0) && !legal;
        uses_rt = (opcode inside {OP_SPECIAL, OP_BEQ, OP_BNE,
                                  6'b101000, 6'b101001, 6'b101011});
        is_j    = (opcode inside {OP_J, OP_JAL});
        is_jr   = (opcode == OP_SPECIAL) && (funct inside {FN_JR, FN_JALR});

        waddr = '0;
        if (!ri) begin
            case (opcode)
                OP_SPECIAL: waddr = (funct == FN_JR) ? 5'd0 : rd;
                OP_JAL:     waddr = 5'd31;
                OP_REGIMM:  waddr = (rt inside {5'b10000, 5'b10001}) ? 5'd31 : 5'd0;
                default: begin
                    if (opcode[5:3] == 3'b001 ||
                        opcode inside {6'b100000, 6'b100001, 6'b100011,
                                       6'b100100, 6'b100101})
                        waddr = rt;
                end
            endcase
        end

        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: imm = {16'h0000, id_inst[15:0]};
            OP_LUI:                   imm = {id_inst[15:0], 16'h0000};
            default:                  imm = {{16{id_inst[15]}}, id_inst[15:0]};
        endcase

        taken = 1'b0;
        case (opcode)
            OP_BEQ:    taken = (rs_data == rt_data);
            OP_BNE:    taken = (rs_data != rt_data);
            OP_BLEZ:   taken = ($signed(rs_data) <= 32'sd0);
            OP_BGTZ:   taken = ($signed(rs_data) >  32'sd0);
            OP_REGIMM: begin
                if (rt inside {5'b00000, 5'b10000})
                    taken = ($signed(rs_data) < 32'sd0);
                else if (rt inside {5'b00001, 5'b10001})
                    taken = ($signed(rs_data) >= 32'sd0);
            end
            default:   taken = 1'b0;
        endcase
    end

    // Load-use hazard against the instruction currently in EX
    always_comb begin
        ex_is_load = (ex_inst[31:26] inside {6'b100000, 6'b100001, 6'b100011,
                                             6'b100100, 6'b100101});
        delay_soft = ex_is_load && (ex_waddr != 5'd0) &&
                     ((ex_waddr == rs) || (uses_rt && (ex_waddr == rt)));
        // a live pulse marks the current instruction as a delay slot
        suppress   = branch_1 | j | jr | ri | intr | delay_hard | delay_soft;
    end

    // Redirect pulses and JR target; suppressed cycles leave jr_data untouched
    always_ff @(posedge clk) begin
        if (!reset) begin
            branch_1   <= 1'b0;
            j          <= 1'b0;
            jr         <= 1'b0;
            jr_data_ok <= 1'b0;
            jr_data    <= '0;
        end else begin
            branch_1   <= taken & ~suppress;
            j          <= is_j & ~suppress;
            jr         <= is_jr & ~suppress;
            jr_data_ok <= is_jr & ~suppress;
            if (is_jr && !suppress)
                jr_data <= rs_data;
        end
    end

    // ID/EX register: reset > flush > hard stall (hold) > load-use bubble > advance
    always_ff @(posedge clk) begin
        if (!reset || intr || (!delay_hard && delay_soft)) begin
            ex_inst   <= '0;
            ex_pc     <= '0;
            ex_rs_val <= '0;
            ex_rt_val <= '0;
            ex_imm    <= '0;
            ex_waddr  <= '0;
            ex_IC     <= '0;
        end else if (!delay_hard) begin
            ex_inst   <= id_inst;
            ex_pc     <= id_pc;
            ex_rs_val <= rs_data;
            ex_rt_val <= rt_data;
            ex_imm    <= imm;
            ex_waddr  <= waddr;
            ex_IC     <= {ri, IC_IF};
        end
    end

endmodule

// File: tb/tb_id_1.sv
// Scoreboard bench for id_1: the driver pushes the expected per-cycle view
// from a behavioural model; a negedge monitor pops and compares.
module tb_id_1;

    logic        clk = 1'b0;
    logic        reset, intr, delay_hard;
    logic [31:0] id_inst, id_pc, rs_data, rt_data;
    logic [1:0]  IC_IF;
    logic [4:0]  rs_addr, rt_addr, ex_waddr;
    logic        branch_1, j, jr, jr_data_ok, delay_soft;
    logic [31:0] jr_data, ex_inst, ex_pc, ex_rs_val, ex_rt_val, ex_imm;
    logic [2:0]  ex_IC;

    always #5 clk = ~clk;

    id_1 #(.RI_CHECK(1)) dut (
        .clk(clk), .reset(reset), .intr(intr), .delay_hard(delay_hard),
        .id_inst(id_inst), .id_pc(id_pc), .IC_IF(IC_IF),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .branch_1(branch_1), .j(j), .jr(jr), .jr_data(jr_data), .jr_data_ok(jr_data_ok),
        .delay_soft(delay_soft), .ex_inst(ex_inst), .ex_pc(ex_pc),
        .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm),
        .ex_waddr(ex_waddr), .ex_IC(ex_IC)
    );

    typedef struct {
        logic [4:0]  rs_addr, rt_addr;
        logic        delay_soft;
        logic [31:0] ex_inst, ex_pc, ex_rs_val, ex_rt_val, ex_imm;
        logic [4:0]  ex_waddr;
        logic [2:0]  ex_IC;
        logic        branch_1, j, jr, jr_data_ok;
        logic [31:0] jr_data;
    } exp_t;

    exp_t        q[$];
    exp_t        m;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] pc = 32'hbfc0_0000;
    bit          last_stall = 0;

    function automatic bit is_load(input logic [5:0] op);
        return op inside {6'd32, 6'd33, 6'd35, 6'd36, 6'd37};
    endfunction

    function automatic bit legal_op(input logic [5:0] op);
        return (op <= 6'd15) || (op inside {6'd16, 6'd32, 6'd33, 6'd35, 6'd36,
                                            6'd37, 6'd40, 6'd41, 6'd43});
    endfunction

    task automatic clear_ex();
        m.ex_inst = 0; m.ex_pc = 0; m.ex_rs_val = 0; m.ex_rt_val = 0;
        m.ex_imm = 0; m.ex_waddr = 0; m.ex_IC = 0;
    endtask

    // One ID cycle: apply inputs, push what the DUT must show, advance the model
    task automatic drive(input logic [31:0] inst, input logic [31:0] rsd,
                         input logic [31:0] rtd, input logic [1:0] icif,
                         input logic it, input logic dh, input logic rst);
        logic [5:0]  op, fn;
        logic [4:0]  s, t, d, wa;
        logic [31:0] im;
        int          a;
        bit          ri, ds, tk, jf, jrf, sup, urt;
        exp_t        e;
        @(posedge clk);
        #1;
        id_inst = inst; id_pc = pc; rs_data = rsd; rt_data = rtd;
        IC_IF = icif; intr = it; delay_hard = dh; reset = rst;

        op = inst[31:26]; s = inst[25:21]; t = inst[20:16];
        d = inst[15:11];  fn = inst[5:0];  a = $signed(rsd);
        ri  = !legal_op(op);
        urt = (op == 6'd0) || (op inside {6'd4, 6'd5, 6'd40, 6'd41, 6'd43});
        ds  = is_load(m.ex_inst[31:26]) && (m.ex_waddr != 0) &&
              ((m.ex_waddr == s) || (urt && (m.ex_waddr == t)));

        e = m; e.rs_addr = s; e.rt_addr = t; e.delay_soft = ds;
        q.push_back(e);
        last_stall = rst && (ds || dh);

        wa = 0;
        if (!ri) begin
            if (op == 6'd0)                            wa = (fn == 6'd8) ? 5'd0 : d;
            else if (op == 6'd3)                       wa = 31;
            else if (op == 6'd1)                       wa = (t == 16 || t == 17) ? 5'd31 : 5'd0;
            else if ((op >= 8 && op <= 15) || is_load(op)) wa = t;
        end
        if (op inside {6'd12, 6'd13, 6'd14}) im = {16'h0, inst[15:0]};
        else if (op == 6'd15)              im = {inst[15:0], 16'h0};
        else                               im = 32'($signed(inst[15:0]));

        case (op)
            6'd4: tk = (rsd == rtd);
            6'd5: tk = (rsd != rtd);
            6'd6: tk = (a <= 0);
            6'd7: tk = (a > 0);
            6'd1: tk = ((t == 0 || t == 16) && a < 0) || ((t == 1 || t == 17) && a >= 0);
            default: tk = 0;
        endcase
        jf  = (op == 6'd2) || (op == 6'd3);
        jrf = (op == 6'd0) && (fn == 6'd8 || fn == 6'd9);
        sup = m.branch_1 || m.j || m.jr || ri || it || dh || ds;

        if (!rst) begin
            clear_ex();
            m.branch_1 = 0; m.j = 0; m.jr = 0; m.jr_data_ok = 0; m.jr_data = 0;
        end else begin
            m.branch_1 = tk && !sup;
            m.j        = jf && !sup;
            m.jr       = jrf && !sup;
            m.jr_data_ok = jrf && !sup;
            if (jrf && !sup) m.jr_data = rsd;
            if (it) clear_ex();
            else if (dh) ;
            else if (ds) clear_ex();
            else begin
                m.ex_inst = inst; m.ex_pc = pc; m.ex_rs_val = rsd; m.ex_rt_val = rtd;
                m.ex_imm = im; m.ex_waddr = wa; m.ex_IC = {ri, icif};
            end
        end
        if (!last_stall) pc = pc + 4;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare every cycle's outputs against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rs_addr",    32'(rs_addr),    32'(e.rs_addr));
                chk("rt_addr",    32'(rt_addr),    32'(e.rt_addr));
                chk("delay_soft", 32'(delay_soft), 32'(e.delay_soft));
                chk("ex_inst",    ex_inst,         e.ex_inst);
                chk("ex_pc",      ex_pc,           e.ex_pc);
                chk("ex_rs_val",  ex_rs_val,       e.ex_rs_val);
                chk("ex_rt_val",  ex_rt_val,       e.ex_rt_val);
                chk("ex_imm",     ex_imm,          e.ex_imm);
                chk("ex_waddr",   32'(ex_waddr),   32'(e.ex_waddr));
                chk("ex_IC",      32'(ex_IC),      32'(e.ex_IC));
                chk("branch_1",   32'(branch_1),   32'(e.branch_1));
                chk("j",          32'(j),          32'(e.j));
                chk("jr",         32'(jr),         32'(e.jr));
                chk("jr_data_ok", 32'(jr_data_ok), 32'(e.jr_data_ok));
                chk("jr_data",    jr_data,         e.jr_data);
            end
        end
    end

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd5;
            2: return 32'hffff_ffff;
            3: return 32'd1;
            4: return 32'h8000_0000;
            5: return 32'h7fff_ffff;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0] ops[22];
        logic [5:0] fns[5];
        logic [4:0] rts[5];
        logic [5:0] op, fn;
        logic [4:0] s, t, d;
        logic [15:0] im;
        ops = '{6'd0, 6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9,
                6'd12, 6'd13, 6'd14, 6'd15, 6'd32, 6'd35, 6'd36, 6'd40, 6'd43,
                6'd63, 6'd17};
        fns = '{6'h21, 6'h23, 6'h08, 6'h09, 6'h2a};
        rts = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd3};
        if ($urandom_range(0, 9) == 0) return 32'h0;
        op = ops[$urandom_range(0, 21)];
        s  = 5'($urandom_range(0, 7));
        t  = 5'($urandom_range(0, 7));
        d  = 5'($urandom_range(0, 7));
        im = 16'($urandom);
        fn = fns[$urandom_range(0, 4)];
        if (op == 6'd1) t = rts[$urandom_range(0, 4)];
        if (op == 6'd0) return {op, s, t, d, 5'd0, fn};
        return {op, s, t, im};
    endfunction

    localparam logic [31:0] NOP = 32'h0;

    // Stimulus: reset, directed scenarios, then constrained-random traffic
    initial begin
        logic [31:0] ri_inst, rr, rt2;
        logic [1:0]  ic;
        logic        it, dh, rst;
        reset = 0; intr = 0; delay_hard = 0; id_inst = 0; id_pc = 0;
        rs_data = 0; rt_data = 0; IC_IF = 0;
        m = '{default: '0};
        repeat (2) @(posedge clk);

        // reset state held one more cycle, then taken BEQ and its delay slot
        drive(NOP, 0, 0, 2'b00, 0, 0, 0);
        drive({6'd4, 5'd1, 5'd2, 16'h0010}, 5, 5, 2'b00, 0, 0, 1);
        drive({6'd5, 5'd1, 5'd2, 16'h0020}, 1, 2, 2'b00, 0, 0, 1);
        drive(NOP, 0, 0, 2'b00, 0, 0, 1);
        // load-use: LW $3 then ADDU $4,$3,$5 (re-presented after bubble)
        drive({6'd35, 5'd0, 5'd3, 16'h0004}, 0, 0, 2'b00, 0, 0, 1);
        drive({6'd0, 5'd3, 5'd5, 5'd4, 5'd0, 6'h21}, 7, 9, 2'b00, 0, 0, 1);
        drive({6'd0, 5'd3, 5'd5, 5'd4, 5'd0, 6'h21}, 7, 9, 2'b00, 0, 0, 1);
        drive(NOP, 0, 0, 2'b00, 0, 0, 1);
        // JR $31
        drive({6'd0, 5'd31, 15'd0, 6'h08}, 32'hbfc0_0100, 0, 2'b00, 0, 0, 1);
        drive(NOP, 0, 0, 2'b00, 0, 0, 1);
        drive(NOP, 0, 0, 2'b00, 0, 0, 1);
        // reserved opcode with fetch exception bits
        drive({6'h3f, 5'd2, 5'd6, 16'h1234}, 3, 4, 2'b01, 0, 0, 1);
        drive(NOP, 0, 0, 2'b00, 0, 0, 1);
        // JAL held by delay_hard for three cycles, then released
        drive({6'd3, 26'h0123456}, 0, 0, 2'b00, 0, 1, 1);
        drive({6'd3, 26'h0123456}, 0, 0, 2'b00, 0, 1, 1);
        drive({6'd3, 26'h0123456}, 0, 0, 2'b00, 0, 1, 1);
        drive({6'd3, 26'h0123456}, 0, 0, 2'b00, 0, 0, 1);
        drive(NOP, 0, 0, 2'b00, 0, 0, 1);
        // flush during load-use stall, then reset during load-use stall
        drive({6'd35, 5'd0, 5'd3, 16'h0008}, 0, 0, 2'b00, 0, 0, 1);
        drive({6'd0, 5'd3, 5'd5, 5'd4, 5'd0, 6'h21}, 1, 2, 2'b00, 1, 0, 1);
        drive({6'd35, 5'd0, 5'd3, 16'h0008}, 0, 0, 2'b00, 0, 0, 1);
        drive({6'd4, 5'd3, 5'd3, 16'h0002}, 1, 1, 2'b00, 0, 0, 0);
        drive(NOP, 0, 0, 2'b00, 0, 0, 1);

        ri_inst = NOP; rr = 0; rt2 = 0; ic = 0;
        for (int i = 0; i < 500; i++) begin
            if (!last_stall || $urandom_range(0, 9) == 0) begin
                ri_inst = rand_inst();
                rr  = rand_data();
                rt2 = ($urandom_range(0, 3) == 0) ? rr : rand_data();
                ic  = 2'($urandom_range(0, 3));
            end
            it  = ($urandom_range(0, 31) == 0);
            dh  = ($urandom_range(0, 11) == 0);
            rst = ($urandom_range(0, 79) != 0);
            drive(ri_inst, rr, rt2, ic, it, dh, rst);
        end

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
